pll_lock_supervisor: RTL and testbench
======================================

# pll_lock_supervisor

Parametrised supervisor wrapping the on-chip PLL. It drives the PLL reset, watches `locked`, and retries on lock timeout. It releases N per-domain resets in a staggered order once lock is stable, and re-sequences everything on loss of lock. It sits between the PLL primitive wrapper and the clock-domain reset synchronisers in the top level, and runs entirely on the PLL reference clock.

## Interface
Parameters:
- `N_CLK`, 4: number of downstream reset channels (1..16)
- `PLL_RST_LEN`, 16: cycles `pll_rst` is held per attempt (≥2)
- `LOCK_TIMEOUT`, 100000: cycles allowed for lock per attempt
- `LOCK_STABLE`, 1024: consecutive synchronised-lock cycles required before release
- `STAGGER`, 8: cycles between successive channel releases (≥1)
- `MAX_RETRY`, 4: failed attempts before entering FAIL (≥1)
- `CNT_W`, 8: width of the lock-loss counter

Ports:
- `refclk`, in, 1: the single clock
- `rst`, in, 1: synchronous reset, active-high
- `pll_locked`, in, 1: PLL lock. Asynchronous to `refclk`; 2-FF synchronised internally to `lock_s`.
- `force_relock`, in, 1: single-cycle request to restart the sequence
- `pll_rst`, out, 1: reset to the PLL
- `chan_rst`, out, N_CLK: per-domain resets, active-high
- `ready`, out, 1: all channels released, PLL locked
- `fail`, out, 1: retry budget exhausted
- `lost_cnt`, out, CNT_W: saturating count of lock losses while in RUN

## Operation
- All outputs are registered. While `rst` is high:
  - state = RESET_PLL, `pll_rst`=1, `chan_rst`=all 1s, `ready`=0, `fail`=0, `lost_cnt`=0
  - retry count, timers and synchroniser are cleared
- States:
  - **RESET_PLL**
    - `pll_rst`=1 for exactly PLL_RST_LEN cycles, counted from the first cycle `rst` is low or from state entry.
    - Then → WAIT_LOCK.
  - **WAIT_LOCK**
    - `pll_rst`=0; the timeout timer runs.
    - `lock_s`=1 → STABLE.
    - On timer = LOCK_TIMEOUT−1, retry+1. If the new retry count = MAX_RETRY → FAIL, else → RESET_PLL.
  - **STABLE**
    - Counts consecutive `lock_s`=1 cycles.
    - `lock_s`=0 → WAIT_LOCK, with the timeout timer restarted.
    - On count = LOCK_STABLE−1 → RELEASE, and the retry count clears.
  - **RELEASE**
    - The stagger counter counts 0..STAGGER−1. Each wrap deasserts the next `chan_rst` bit, LSB first.
    - Bit 0 falls STAGGER cycles after RELEASE entry.
    - When the MSB falls, `ready` rises in the same cycle → RUN.
  - **RUN**
    - Holds `ready`=1 and `chan_rst`=0.
  - **FAIL**
    - `pll_rst`=1, `chan_rst`=all 1s, `fail`=1.
    - Exits only on `rst`; `force_relock` is ignored.
- Loss of lock:
  - `lock_s`=0 in RELEASE or RUN → next cycle `chan_rst`=all 1s, `ready`=0, state RESET_PLL.
  - `lost_cnt` increments only when the loss occurs in RUN, saturating at 2^CNT_W−1.
- `force_relock`=1 in any state except FAIL → next cycle RESET_PLL, `chan_rst`=all 1s, `ready`=0, no `lost_cnt` increment.
- Simultaneous `force_relock` and lock loss in RUN → counted as a loss (`lost_cnt`+1).
- Retry count clears only on `rst` or on reaching RELEASE. A lock loss does not clear it, and a relock after loss does not consume a retry.
- All counter widths are `$clog2(limit+1)`. There is no wrap; each counter resets on state entry.

## Timing
- Synchroniser latency: `lock_s` follows `pll_locked` by 2 cycles.
- From the first cycle `pll_locked` is sampled high, with no glitches:
  - RELEASE entry at +2+LOCK_STABLE
  - `chan_rst[i]` falls at +2+LOCK_STABLE+(i+1)·STAGGER
  - `ready` rises together with `chan_rst[N_CLK−1]`
- Lock loss to `chan_rst` assertion: 3 cycles from the `pll_locked` fall (2 synchroniser + 1 register).
- `pll_rst` pulses are exactly PLL_RST_LEN cycles wide. There are no gaps between back-to-back retries other than the WAIT_LOCK window.

## Structure
- Package `pll_sup_pkg`: state enum (RESET_PLL, WAIT_LOCK, STABLE, RELEASE, RUN, FAIL) and a `clog2`-based width helper.
- Sub-module `sync2`: 2-FF synchroniser with reset value 0, reusable elsewhere.
- The FSM, timers and stagger shifter live in the top module.

## Test plan
Use N_CLK=3, PLL_RST_LEN=4, LOCK_TIMEOUT=32, LOCK_STABLE=8, STAGGER=2, MAX_RETRY=2, CNT_W=2.

- Nominal: `rst` low at t=0, `pll_locked` high at t=10 → `pll_rst` high t=0..3; `chan_rst` bits fall at t=22, 24, 26; `ready`=1 at t=26.
- Timeout: `pll_locked` held 0 → two `pll_rst` pulses of 4 cycles, then `fail`=1 and `pll_rst`=1 from the second timeout onward; `force_relock` has no effect.
- Lock glitch: `pll_locked` low for 1 cycle during STABLE → stable count restarts; release is delayed by the glitch offset; no retry consumed.
- Loss in RUN, repeated 4 times → `chan_rst`=3'b111 three cycles after each fall; `lost_cnt` reads 1, 2, 3, 3 (saturates).
- `force_relock` in RUN, and separately together with a lock loss → `lost_cnt` unchanged in the first case and +1 in the second; both return to RESET_PLL.
- `rst` asserted mid-RELEASE → next cycle all outputs at reset values; the sequence restarts cleanly.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// -----------------------------------------------------------------------------
// pll_sup_pkg
// Shared types and helpers for the PLL lock supervisor.
//   pll_state_e : supervisor FSM states
//   cnt_w()     : width of a counter that must be able to hold 0..limit
// -----------------------------------------------------------------------------
package pll_sup_pkg;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAIL      = 3'd5
    } pll_state_e;

    // Width needed to represent every value 0..limit (never less than 1 bit).
    function automatic int cnt_w(input int limit);
        int w;
        if (limit < 1) begin
            w = 1;
        end else begin
            w = $clog2(limit + 1);
        end
        return w;
    endfunction

endpackage

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchroniser for a single asynchronous level, reset value 0.
// Ports:
//   clk : destination clock
//   rst : synchronous reset, active-high
//   d   : asynchronous input
//   q   : synchronised output (two cycles of latency)
// -----------------------------------------------------------------------------
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic q_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= 1'b0;
            q_r    <= 1'b0;
        end else begin
            meta_r <= d;
            q_r    <= meta_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
// Drives the PLL reset, waits for lock with a per-attempt timeout and a retry
// budget, requires a stable lock before releasing the downstream resets one
// channel at a time, and re-sequences on loss of lock or on request.
// Ports:
//   refclk       : PLL reference clock (only clock)
//   rst          : synchronous reset, active-high
//   pll_locked   : asynchronous PLL lock indication
//   force_relock : single-cycle request to restart the sequence
//   pll_rst      : reset to the PLL
//   chan_rst     : per-domain resets, active-high, released LSB first
//   ready        : all channels released and PLL locked
//   fail         : retry budget exhausted (sticky until rst)
//   lost_cnt     : saturating count of lock losses seen while running
// -----------------------------------------------------------------------------
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int N_CLK        = 4,
    parameter int PLL_RST_LEN  = 16,
    parameter int LOCK_TIMEOUT = 100000,
    parameter int LOCK_STABLE  = 1024,
    parameter int STAGGER      = 8,
    parameter int MAX_RETRY    = 4,
    parameter int CNT_W        = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             force_relock,
    output logic             pll_rst,
    output logic [N_CLK-1:0] chan_rst,
    output logic             ready,
    output logic             fail,
    output logic [CNT_W-1:0] lost_cnt
);

    localparam int RST_W  = cnt_w(PLL_RST_LEN);
    localparam int TMO_W  = cnt_w(LOCK_TIMEOUT);
    localparam int STAB_W = cnt_w(LOCK_STABLE);
    localparam int STAG_W = cnt_w(STAGGER);
    localparam int RTY_W  = cnt_w(MAX_RETRY);

    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(PLL_RST_LEN - 1);
    localparam logic [RST_W-1:0]  RST_ONE   = RST_W'(1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMO_W-1:0]  TMO_ONE   = TMO_W'(1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE - 1);
    localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
    localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'(STAGGER - 1);
    localparam logic [STAG_W-1:0] STAG_ONE  = STAG_W'(1);
    localparam logic [RTY_W-1:0]  RTY_MAX   = RTY_W'(MAX_RETRY);
    localparam logic [RTY_W-1:0]  RTY_ONE   = RTY_W'(1);
    localparam logic [CNT_W-1:0]  LOST_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  LOST_SAT  = {CNT_W{1'b1}};
    localparam logic [N_CLK-1:0]  CHAN_ALL  = {N_CLK{1'b1}};
    localparam logic [N_CLK-1:0]  CHAN_NONE = {N_CLK{1'b0}};

    logic lock_s;

    pll_state_e        state_r,    state_s;
    logic [RST_W-1:0]  rst_tmr_r,  rst_tmr_s;
    logic [TMO_W-1:0]  tmo_tmr_r,  tmo_tmr_s;
    logic [STAB_W-1:0] stab_cnt_r, stab_cnt_s;
    logic [STAG_W-1:0] stag_cnt_r, stag_cnt_s;
    logic [RTY_W-1:0]  retry_r,    retry_s;
    logic              pll_rst_r,  pll_rst_s;
    logic [N_CLK-1:0]  chan_rst_r, chan_rst_s;
    logic              ready_r,    ready_s;
    logic              fail_r,     fail_s;
    logic [CNT_W-1:0]  lost_cnt_r, lost_cnt_s;

    logic [RTY_W-1:0]  retry_inc_s;
    logic [CNT_W-1:0]  lost_inc_s;
    logic [N_CLK-1:0]  chan_shift_s;

    sync2 u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    // Next-state, counter and output computation for the supervisor FSM.
    always_comb begin
        state_s    = state_r;
        // Counters hold only while their state is active, so each one is
        // automatically zero on entry to its state.
        rst_tmr_s  = {RST_W{1'b0}};
        tmo_tmr_s  = {TMO_W{1'b0}};
        stab_cnt_s = {STAB_W{1'b0}};
        stag_cnt_s = {STAG_W{1'b0}};
        retry_s    = retry_r;
        pll_rst_s  = pll_rst_r;
        chan_rst_s = chan_rst_r;
        ready_s    = ready_r;
        fail_s     = fail_r;
        lost_cnt_s = lost_cnt_r;

        retry_inc_s  = retry_r + RTY_ONE;
        lost_inc_s   = (lost_cnt_r == LOST_SAT) ? lost_cnt_r : (lost_cnt_r + LOST_ONE);
        // Shifting a zero in at the LSB releases channels lowest index first.
        chan_shift_s = chan_rst_r << 1'b1;

        if (force_relock && (state_r != ST_FAIL)) begin
            // A request overrides everything except FAIL; a lock loss seen in
            // RUN on the same cycle is still counted.
            state_s    = ST_RESET_PLL;
            pll_rst_s  = 1'b1;
            chan_rst_s = CHAN_ALL;
            ready_s    = 1'b0;
            fail_s     = 1'b0;
            if ((state_r == ST_RUN) && !lock_s) begin
                lost_cnt_s = lost_inc_s;
            end else begin
                lost_cnt_s = lost_cnt_r;
            end
        end else begin
            case (state_r)
                ST_RESET_PLL: begin
                    pll_rst_s  = 1'b1;
                    chan_rst_s = CHAN_ALL;
                    ready_s    = 1'b0;
                    fail_s     = 1'b0;
                    if (rst_tmr_r >= RST_LAST) begin
                        state_s   = ST_WAIT_LOCK;
                        pll_rst_s = 1'b0;
                    end else begin
                        rst_tmr_s = rst_tmr_r + RST_ONE;
                    end
                end

                ST_WAIT_LOCK: begin
                    pll_rst_s = 1'b0;
                    if (lock_s) begin
                        // The cycle that saw lock already counts as stable.
                        state_s    = ST_STABLE;
                        stab_cnt_s = STAB_ONE;
                    end else if (tmo_tmr_r >= TMO_LAST) begin
                        retry_s   = retry_inc_s;
                        pll_rst_s = 1'b1;
                        if (retry_inc_s >= RTY_MAX) begin
                            state_s = ST_FAIL;
                            fail_s  = 1'b1;
                        end else begin
                            state_s = ST_RESET_PLL;
                        end
                    end else begin
                        tmo_tmr_s = tmo_tmr_r + TMO_ONE;
                    end
                end

                ST_STABLE: begin
                    if (!lock_s) begin
                        state_s = ST_WAIT_LOCK;
                    end else if (stab_cnt_r >= STAB_LAST) begin
                        state_s = ST_RELEASE;
                        retry_s = {RTY_W{1'b0}};
                    end else begin
                        stab_cnt_s = stab_cnt_r + STAB_ONE;
                    end
                end

                ST_RELEASE: begin
                    if (!lock_s) begin
                        state_s    = ST_RESET_PLL;
                        pll_rst_s  = 1'b1;
                        chan_rst_s = CHAN_ALL;
                        ready_s    = 1'b0;
                    end else if (stag_cnt_r >= STAG_LAST) begin
                        chan_rst_s = chan_shift_s;
                        if (chan_shift_s == CHAN_NONE) begin
                            state_s = ST_RUN;
                            ready_s = 1'b1;
                        end else begin
                            state_s = ST_RELEASE;
                        end
                    end else begin
                        stag_cnt_s = stag_cnt_r + STAG_ONE;
                    end
                end

                ST_RUN: begin
                    if (!lock_s) begin
                        state_s    = ST_RESET_PLL;
                        pll_rst_s  = 1'b1;
                        chan_rst_s = CHAN_ALL;
                        ready_s    = 1'b0;
                        lost_cnt_s = lost_inc_s;
                    end else begin
                        chan_rst_s = CHAN_NONE;
                        ready_s    = 1'b1;
                    end
                end

                ST_FAIL: begin
                    pll_rst_s  = 1'b1;
                    chan_rst_s = CHAN_ALL;
                    ready_s    = 1'b0;
                    fail_s     = 1'b1;
                end

                default: begin
                    state_s    = ST_RESET_PLL;
                    pll_rst_s  = 1'b1;
                    chan_rst_s = CHAN_ALL;
                    ready_s    = 1'b0;
                    fail_s     = 1'b0;
                end
            endcase
        end
    end

    // State, counter and registered-output update with synchronous reset.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_r    <= ST_RESET_PLL;
            rst_tmr_r  <= {RST_W{1'b0}};
            tmo_tmr_r  <= {TMO_W{1'b0}};
            stab_cnt_r <= {STAB_W{1'b0}};
            stag_cnt_r <= {STAG_W{1'b0}};
            retry_r    <= {RTY_W{1'b0}};
            pll_rst_r  <= 1'b1;
            chan_rst_r <= CHAN_ALL;
            ready_r    <= 1'b0;
            fail_r     <= 1'b0;
            lost_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_s;
            rst_tmr_r  <= rst_tmr_s;
            tmo_tmr_r  <= tmo_tmr_s;
            stab_cnt_r <= stab_cnt_s;
            stag_cnt_r <= stag_cnt_s;
            retry_r    <= retry_s;
            pll_rst_r  <= pll_rst_s;
            chan_rst_r <= chan_rst_s;
            ready_r    <= ready_s;
            fail_r     <= fail_s;
            lost_cnt_r <= lost_cnt_s;
        end
    end

    assign pll_rst  = pll_rst_r;
    assign chan_rst = chan_rst_r;
    assign ready    = ready_r;
    assign fail     = fail_r;
    assign lost_cnt = lost_cnt_r;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_supervisor
// Scoreboard bench: the stimulus process queues every expected change of the
// output tuple {pll_rst, chan_rst, ready, fail, lost_cnt} with the cycle it
// must appear in (relative to the first cycle rst is low); the monitor pops
// and compares each time the tuple changes.
// -----------------------------------------------------------------------------
module tb_pll_lock_supervisor;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       force_relock;
    logic       pll_rst;
    logic [2:0] chan_rst;
    logic       ready;
    logic       fail;
    logic [1:0] lost_cnt;

    typedef struct {
        int         t;
        logic [7:0] v;
        string      tag;
    } ev_t;

    ev_t q[$];
    int  cyc    = 0;
    int  base   = 0;
    int  checks = 0;
    int  errors = 0;

    pll_lock_supervisor #(
        .N_CLK(3), .PLL_RST_LEN(4), .LOCK_TIMEOUT(32), .LOCK_STABLE(8),
        .STAGGER(2), .MAX_RETRY(2), .CNT_W(2)
    ) dut (
        .refclk       (clk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .force_relock (force_relock),
        .pll_rst      (pll_rst),
        .chan_rst     (chan_rst),
        .ready        (ready),
        .fail         (fail),
        .lost_cnt     (lost_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int t, input logic p, input logic [2:0] c, input logic r,
                        input logic f, input logic [1:0] l, input string tag);
        ev_t e;
        e.t   = t;
        e.v   = {p, c, r, f, l};
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic wait_t(input int t);
        while ((cyc - base) < t) @(negedge clk);
    endtask

    // Reset values are expected at exp_t (relative to the old anchor), or at
    // any time when exp_t is negative; the anchor moves to the first low cycle.
    task automatic do_reset(input int exp_t);
        push(exp_t, 1'b1, 3'b111, 1'b0, 1'b0, 2'd0, "reset_values");
        rst          = 1'b1;
        pll_locked   = 1'b0;
        force_relock = 1'b0;
        repeat (3) @(negedge clk);
        rst  = 1'b0;
        base = cyc;
    endtask

    // Fresh start with pll_locked raised at cycle 10.
    task automatic push_nominal(input logic [1:0] l);
        push(4,  1'b0, 3'b111, 1'b0, 1'b0, l, "wait_lock_entry");
        push(22, 1'b0, 3'b110, 1'b0, 1'b0, l, "chan0_release");
        push(24, 1'b0, 3'b100, 1'b0, 1'b0, l, "chan1_release");
        push(26, 1'b0, 3'b000, 1'b1, 1'b0, l, "chan2_ready");
    endtask

    // Re-sequence entered at t0 with lock already present again by t0+4.
    task automatic push_relock(input int t0, input logic [1:0] l);
        push(t0,      1'b1, 3'b111, 1'b0, 1'b0, l, "reseq_entry");
        push(t0 + 4,  1'b0, 3'b111, 1'b0, 1'b0, l, "reseq_wait_lock");
        push(t0 + 14, 1'b0, 3'b110, 1'b0, 1'b0, l, "reseq_chan0");
        push(t0 + 16, 1'b0, 3'b100, 1'b0, 1'b0, l, "reseq_chan1");
        push(t0 + 18, 1'b0, 3'b000, 1'b1, 1'b0, l, "reseq_ready");
    endtask

    // Monitor: every change of the output tuple is matched against the queue.
    initial begin
        logic [7:0] prev;
        logic [7:0] cur;
        ev_t        e;
        prev = 8'bxxxx_xxxx;
        forever begin
            @(negedge clk);
            cur = {pll_rst, chan_rst, ready, fail, lost_cnt};
            if (cur !== prev) begin
                prev = cur;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change t=%0d got=%b want=no_change", cyc - base, cur);
                end else begin
                    e = q.pop_front();
                    if ((cur !== e.v) || ((e.t >= 0) && ((cyc - base) != e.t))) begin
                        errors++;
                        $display("FAIL %s got=%b at t=%0d want=%b at t=%0d",
                                 e.tag, cur, cyc - base, e.v, e.t);
                    end
                end
            end
        end
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    // Stimulus.
    initial begin
        rst          = 1'b1;
        pll_locked   = 1'b0;
        force_relock = 1'b0;

        // Nominal bring-up, then four losses in RUN (lost_cnt 1,2,3,3).
        do_reset(-1);
        push_nominal(2'd0);
        wait_t(10); pll_locked = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int f;
            f = 30 + 25 * k;
            wait_t(f);
            pll_locked = 1'b0;
            push_relock(f + 3, (k < 3) ? 2'(k + 1) : 2'd3);
            wait_t(f + 2);
            pll_locked = 1'b1;
        end
        wait_t(130);

        // force_relock alone, then together with a lock loss.
        do_reset(-1);
        push_nominal(2'd0);
        wait_t(10); pll_locked = 1'b1;
        wait_t(30); force_relock = 1'b1;
        push_relock(31, 2'd0);
        wait_t(31); force_relock = 1'b0;
        wait_t(53); pll_locked = 1'b0;
        wait_t(55); force_relock = 1'b1; pll_locked = 1'b1;
        push_relock(56, 2'd1);
        wait_t(56); force_relock = 1'b0;
        wait_t(80);

        // One-cycle lock glitch during STABLE delays release by 6 cycles.
        do_reset(-1);
        push(4,  1'b0, 3'b111, 1'b0, 1'b0, 2'd0, "glitch_wait_lock");
        push(28, 1'b0, 3'b110, 1'b0, 1'b0, 2'd0, "glitch_chan0");
        push(30, 1'b0, 3'b100, 1'b0, 1'b0, 2'd0, "glitch_chan1");
        push(32, 1'b0, 3'b000, 1'b1, 1'b0, 2'd0, "glitch_ready");
        wait_t(10); pll_locked = 1'b1;
        wait_t(15); pll_locked = 1'b0;
        wait_t(16); pll_locked = 1'b1;
        wait_t(40);

        // rst asserted mid-RELEASE, then a clean restart.
        do_reset(-1);
        push(4,  1'b0, 3'b111, 1'b0, 1'b0, 2'd0, "rel_wait_lock");
        push(22, 1'b0, 3'b110, 1'b0, 1'b0, 2'd0, "rel_chan0");
        wait_t(10); pll_locked = 1'b1;
        wait_t(23);
        do_reset(24);
        push_nominal(2'd0);
        wait_t(10); pll_locked = 1'b1;
        wait_t(30);

        // Lock never arrives: two 4-cycle pll_rst pulses, then FAIL.
        do_reset(-1);
        push(4,  1'b0, 3'b111, 1'b0, 1'b0, 2'd0, "tmo_wait1");
        push(36, 1'b1, 3'b111, 1'b0, 1'b0, 2'd0, "tmo_retry_pulse");
        push(40, 1'b0, 3'b111, 1'b0, 1'b0, 2'd0, "tmo_wait2");
        push(72, 1'b1, 3'b111, 1'b0, 1'b1, 2'd0, "tmo_fail");
        wait_t(80); force_relock = 1'b1;
        wait_t(81); force_relock = 1'b0;
        wait_t(100);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL leftover_events got=%0d want=0 next=%s", q.size(), q[0].tag);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
